// File: rtl/alu_frame_assembler.sv
// alu_frame_assembler: gathers tagged A/B/opcode words into one ALU operation with valid/ready issue; RX_TIMEOUT_EN adds a partial-frame timeout
module alu_frame_assembler #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int NB_TAG      = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NB_TAG+NB_DATA-1:0] i_word,
  input  logic                      i_word_valid,
  output logic                      o_word_ready,
  input  logic                      i_tx_busy,
  output logic [NB_DATA-1:0]        o_operand_a,
  output logic [NB_DATA-1:0]        o_operand_b,
  output logic [NB_OP-1:0]          o_opcode,
  output logic                      o_data_valid,
  input  logic                      i_data_ready,
  output logic                      o_dup_err,
  output logic                      o_tag_err,
  output logic                      o_timeout
);
  typedef enum logic [1:0] {COLLECT, HOLD, ISSUE} state_t;
  state_t state, state_n;
  logic [NB_TAG-1:0] tag;
  logic [NB_DATA-1:0] payload;
  logic [2:0] flags, flags_n, set_mask;
  logic accept, abort, expire;
  assign {tag, payload} = i_word;
  assign o_word_ready = state == COLLECT;
  assign o_data_valid = state == ISSUE;
  assign accept = i_word_valid & o_word_ready;
  assign set_mask = accept ? {tag == NB_TAG'(2), tag == NB_TAG'(1), tag == NB_TAG'(0)} : 3'b000;
  assign abort = accept & (tag == NB_TAG'(3));
  // flags stay set through HOLD/ISSUE so the frame is only retired by the handshake
  always_comb begin
    state_n = state;
    flags_n = flags;
    case (state)
      COLLECT: begin
        flags_n = (abort | expire) ? 3'b000 : flags | set_mask;
        if (&flags_n) state_n = i_tx_busy ? HOLD : ISSUE;
      end
      HOLD: state_n = i_tx_busy ? HOLD : ISSUE;
      ISSUE: begin
        state_n = i_data_ready ? COLLECT : ISSUE;
        flags_n = i_data_ready ? 3'b000 : flags;
      end
      default: state_n = COLLECT;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state <= COLLECT;
      flags <= 3'b000;
    end else begin
      state <= state_n;
      flags <= flags_n;
    end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      o_operand_a <= '0;
      o_operand_b <= '0;
      o_opcode    <= '0;
      o_dup_err   <= 1'b0;
      o_tag_err   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      if (set_mask[0]) o_operand_a <= payload;
      if (set_mask[1]) o_operand_b <= payload;
      if (set_mask[2]) o_opcode <= payload[NB_OP-1:0];
      o_dup_err <= |(set_mask & flags);
      o_tag_err <= accept & ~|set_mask & ~abort;
      o_timeout <= expire;
    end
`ifdef RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  logic run;
  assign run = (state == COLLECT) & |flags & ~accept;
  assign expire = run & (cnt == CW'(TIMEOUT_CYC - 1));
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) cnt <= '0;
    else cnt <= (run & ~expire) ? cnt + 1'b1 : '0;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign expire = 1'b0;
`endif
endmodule

// File: tb/tb_alu_frame_assembler.sv
// tb_alu_frame_assembler: directed + random stimulus against a frame-level reference model with a scoreboard of issued operations
module tb_alu_frame_assembler;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic word_valid = 1'b0, tx_busy = 1'b0, data_ready = 1'b0;
  logic [10:0] word = '0;
  logic word_ready, data_valid, dup_err, tag_err, timeout;
  logic [7:0] op_a, op_b;
  logic [5:0] opcode;
  int checks = 0, errors = 0;
  int frames = 0, dup_seen = 0, to_seen = 0;
  bit mon_en = 0;

  alu_frame_assembler #(.NB_DATA(8), .NB_OP(6), .NB_TAG(3), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_word(word), .i_word_valid(word_valid),
    .o_word_ready(word_ready), .i_tx_busy(tx_busy), .o_operand_a(op_a),
    .o_operand_b(op_b), .o_opcode(opcode), .o_data_valid(data_valid),
    .i_data_ready(data_ready), .o_dup_err(dup_err), .o_tag_err(tag_err),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Reference model: which slots hold a value this frame, the last value per slot,
  // and whether a completed frame is waiting for TX or being offered.
  bit [2:0] have = '0;
  logic [7:0] m_a = '0, m_b = '0, mp;
  logic [5:0] m_op = '0;
  logic [2:0] mt;
  bit m_valid = 0, waiting = 0, e_dup = 0, e_tag = 0, e_to = 0;
  int idle = 0;
  logic [21:0] sb[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have = '0; m_a = '0; m_b = '0; m_op = '0;
      m_valid = 0; waiting = 0; e_dup = 0; e_tag = 0; e_to = 0; idle = 0;
      sb.delete();
    end else begin
      e_dup = 0; e_tag = 0; e_to = 0;
      if (m_valid) begin
        idle = 0;
        if (data_ready) m_valid = 0;
      end else if (waiting) begin
        idle = 0;
        if (!tx_busy) begin waiting = 0; m_valid = 1; end
      end else if (word_valid) begin
        idle = 0;
        {mt, mp} = word;
        case (mt)
          3'd0: begin e_dup = have[0]; have[0] = 1; m_a = mp; end
          3'd1: begin e_dup = have[1]; have[1] = 1; m_b = mp; end
          3'd2: begin e_dup = have[2]; have[2] = 1; m_op = mp[5:0]; end
          3'd3: have = '0;
          default: e_tag = 1;
        endcase
        if (&have) begin
          sb.push_back({m_a, m_b, m_op});
          have = '0;
          if (tx_busy) waiting = 1; else m_valid = 1;
        end
      end else if (|have) begin
`ifdef RX_TIMEOUT_EN
        idle++;
        if (idle == TO) begin have = '0; idle = 0; e_to = 1; end
`endif
      end else idle = 0;
    end
  end

  always @(negedge clk) if (mon_en) begin
    check("word_ready", word_ready, !(m_valid || waiting));
    check("data_valid", data_valid, m_valid);
    check("operand_a", op_a, m_a);
    check("operand_b", op_b, m_b);
    check("opcode", opcode, m_op);
    check("dup_err", dup_err, e_dup);
    check("tag_err", tag_err, e_tag);
    check("timeout", timeout, e_to);
    if (dup_err) dup_seen++;
    if (timeout) to_seen++;
    if (data_valid && data_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got issue {%0h,%0h,%0h} expected no pending frame", op_a, op_b, opcode);
      end else check("frame", {op_a, op_b, opcode}, sb.pop_front());
      frames++;
    end
  end

  function automatic logic [10:0] w(input int t, input int p);
    return {t[2:0], p[7:0]};
  endfunction

  task automatic cyc(input logic v, input logic [10:0] wd, input logic busy, input logic rdy);
    @(posedge clk);
    #2;
    word_valid = v; word = wd; tx_busy = busy; data_ready = rdy;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int f0, d0, t0, r, t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("reset_ready", word_ready, 1);
    check("reset_valid", data_valid, 0);
    check("reset_a", op_a, 0);
    mon_en = 1;
    // basic frame, TX idle
    cyc(1, w(0, 5), 0, 0); cyc(1, w(1, 3), 0, 0); cyc(1, w(2, 1), 0, 0);
    cyc(0, '0, 0, 1); idle_cyc(2);
    check("t1_frames", frames, 1);
    check("t1_a", op_a, 5);
    // TX busy across completion
    cyc(1, w(0, 5), 1, 0); cyc(1, w(1, 3), 1, 0); cyc(1, w(2, 1), 1, 0);
    repeat (8) cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 1); idle_cyc(2);
    check("t2_frames", frames, 2);
    // duplicate A
    d0 = dup_seen;
    cyc(1, w(0, 'h11), 0, 0); cyc(1, w(0, 'h22), 0, 0); cyc(1, w(1, 1), 0, 0); cyc(1, w(2, 'h20), 0, 0);
    cyc(0, '0, 0, 1); idle_cyc(2);
    check("t3_dups", dup_seen - d0, 1);
    check("t3_a", op_a, 'h22);
    // abort then refill
    f0 = frames;
    cyc(1, w(0, 7), 0, 0); cyc(1, w(3, 0), 0, 0); cyc(1, w(1, 4), 0, 0); cyc(1, w(2, 2), 0, 0);
    idle_cyc(3);
    check("t4_noissue", frames - f0, 0);
    cyc(1, w(0, 9), 0, 0); cyc(0, '0, 0, 1); idle_cyc(2);
    check("t4_issue", frames - f0, 1);
    check("t4_a", op_a, 9);
    // unknown tag
    cyc(1, w(5, 'hAA), 0, 0); idle_cyc(2);
    // async reset while issuing
    cyc(1, w(0, 'h3C), 0, 0); cyc(1, w(1, 'h5A), 0, 0); cyc(1, w(2, 'h3F), 0, 0);
    cyc(0, '0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("t5_valid", data_valid, 0);
    check("t5_a", op_a, 0);
    check("t5_op", opcode, 0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("t5_ready", word_ready, 1);
    // partial frame left idle
    f0 = frames; t0 = to_seen;
    cyc(1, w(0, 'h42), 0, 0);
    repeat (TO + 4) cyc(0, '0, 0, 0);
    cyc(1, w(1, 6), 0, 0); cyc(1, w(2, 7), 0, 0);
    cyc(0, '0, 0, 1); idle_cyc(2);
`ifdef RX_TIMEOUT_EN
    check("t6_timeouts", to_seen - t0, 1);
    check("t6_frames", frames - f0, 0);
`else
    check("t6_timeouts", to_seen - t0, 0);
    check("t6_frames", frames - f0, 1);
`endif
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 15);
      t = r < 4 ? 0 : r < 8 ? 1 : r < 12 ? 2 : r == 12 ? 3 : $urandom_range(4, 7);
      cyc($urandom_range(0, 9) < 7, w(t, $urandom_range(0, 255)), $urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));
    end
    idle_cyc(6);
    check("sb_drained", sb.size(), 0);
    check("frames_many", frames > 20, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
